lsu_subword: RTL and testbench

Load/store unit between the core's execute stage and the data port of the unified instruction/data RAM. The RAM only stores whole 32-bit words. This block turns byte, halfword and word requests into word-wide RAM accesses:
- loads: lane extraction plus sign or zero extension;
- sub-word stores: read-modify-write.

The core sees a valid/ready request channel and a single-cycle response pulse.

---
 rtl/lsu_subword_if.sv | 28 ++
 rtl/lsu_subword.sv | 89 ++++++++
 tb/tb_lsu_subword.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_subword_if.sv
// lsu_subword_if: core request/response channel and RAM data port of the load/store unit
interface lsu_subword_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_wEn;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_wEn, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_wEn, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_subword.sv
// lsu_subword: byte/half/word load-store over a word-only RAM (RMW for sub-word stores); LSU_MISALIGN_TRAP_EN enables misalignment trap
module lsu_subword #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input logic         clock,
  input logic         reset_n,
  lsu_subword_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, merge_q, merge_d;
  logic                  accept, misaligned, word_q;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [DATA_WIDTH-1:0] load_ext, merged;
  assign accept = bus.req_valid && bus.req_ready;
  assign word_q = size_q[1];
`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (misaligned ? RESP : ACCESS) : IDLE;
      ACCESS:  state_d = (we_q && !word_q) ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  assign lane_b   = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h   = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  assign load_ext = word_q    ? bus.mem_rdata :
                    size_q[0] ? {{16{~uns_q & lane_h[15]}}, lane_h} :
                                {{24{~uns_q & lane_b[7]}}, lane_b};
  always_comb begin
    merged = bus.mem_rdata;
    if (size_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end
  always_comb begin
    addr_d  = accept ? bus.req_addr : addr_q;
    size_d  = accept ? bus.req_size : size_q;
    we_d    = accept ? bus.req_we : we_q;
    uns_d   = accept ? bus.req_unsigned : uns_q;
    wdata_d = accept ? bus.req_wdata : wdata_q;
    err_d   = accept ? misaligned : err_q;
    rdata_d = accept ? '0 : (state_q == ACCESS && !we_q) ? load_ext : rdata_q;
    merge_d = (state_q == ACCESS && we_q && !word_q) ? merged : merge_q;
  end
  always_comb begin
    bus.req_ready  = state_q == IDLE;
    bus.resp_valid = state_q == RESP;
    bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;
    bus.resp_err   = (state_q == RESP) && err_q;
    bus.mem_wEn    = (state_q == ACCESS && we_q && word_q) || state_q == WRITE;
    bus.mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    bus.mem_wdata  = (state_q == WRITE) ? merge_q : wdata_q;
  end
endmodule

// File: tb/tb_lsu_subword.sv
// tb_lsu_subword: directed vector table, corner sequences and randomized traffic against a byte-level memory model
module tb_lsu_subword;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] ram [64] = '{default: '0};
  logic [31:0] model [64] = '{default: '0};
  lsu_subword_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();
  lsu_subword #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  assign bus.mem_rdata = ram[bus.mem_addr[7:2]];
  always @(posedge clock) if (bus.mem_wEn) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [15:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
  } vec_t;
  vec_t tbl [15];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic logic mis(input logic [1:0] sz, input logic [15:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (sz == 2'd1 && a % 2 != 0) || (sz >= 2'd2 && a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction
  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic int offs(input logic [1:0] sz, input logic [15:0] a);
    int n = nbytes(sz);
    return n == 4 ? 0 : (int'(a) % 4) / n * n;
  endfunction
  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [15:0] a);
    int n = nbytes(sz);
    int o = offs(sz, a);
    logic [63:0] w = {32'b0, model[a[7:2]]};
    logic [63:0] m = (64'h1 << (8 * n)) - 1;
    logic [63:0] v = (w >> (8 * o)) & m;
    if (!uns && n < 4 && v[8 * n - 1]) v = v | (64'hFFFF_FFFF & ~m);
    return v[31:0];
  endfunction
  task automatic model_apply(input logic we, input logic [1:0] sz, input logic [15:0] a, input logic [31:0] wd);
    int n = nbytes(sz);
    int o = offs(sz, a);
    logic [63:0] w = {32'b0, model[a[7:2]]};
    logic [63:0] m = ((64'h1 << (8 * n)) - 1) << (8 * o);
    logic [63:0] d = {32'b0, wd} << (8 * o);
    if (!we || mis(sz, a)) return;
    w = (w & ~m) | (d & m);
    model[a[7:2]] = w[31:0];
  endtask
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [15:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int wc, output int wcyc);
    int t = 0;
    while (!bus.req_ready && t < 10) begin
      @(negedge clock);
      t++;
    end
    if (!bus.req_ready) check("ready_timeout", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = a;
    bus.req_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("ready_low", {31'b0, bus.req_ready}, 32'd0);
    lat = 0; wc = 0; wcyc = 0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clock);
      if (bus.mem_wEn) begin wc++; wcyc = c; end
      if (bus.resp_valid) begin lat = c; rd = bus.resp_rdata; er = bus.resp_err; break; end
    end
    @(negedge clock);
    check("ready_back", {31'b0, bus.req_ready}, 32'd1);
  endtask
  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [15:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
    logic [31:0] rd;
    logic er;
    int lat, wc, wcyc;
    bit wr = we && !exp_er;
    do_req(we, sz, uns, a, wd, rd, er, lat, wc, wcyc);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_er});
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_wen_count"}, 32'(wc), wr ? 32'd1 : 32'd0);
    if (wr) check({tag, "_wen_cycle"}, 32'(wcyc), 32'(exp_lat - 1));
    model_apply(we, sz, a, wd);
  endtask
  initial begin
    int hits;
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 16'h0010, 32'h1122_3344, 32'h0, 1'b0, 2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,         32'h1122_3344, 1'b0, 2};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 16'h0013, 32'h0000_00AB, 32'h0, 1'b0, 3};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,         32'hAB22_3344, 1'b0, 2};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 16'h0013, 32'h0,         32'hFFFF_FFAB, 1'b0, 2};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 16'h0013, 32'h0,         32'h0000_00AB, 1'b0, 2};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 16'h0010, 32'h8001_5555, 32'h0, 1'b0, 2};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 16'h0012, 32'h0,         32'hFFFF_8001, 1'b0, 2};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 16'h0012, 32'h0,         32'h0000_8001, 1'b0, 2};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 16'h0010, 32'h0,         32'h0000_5555, 1'b0, 2};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 16'h0010, 32'h1234_BEEF, 32'h0, 1'b0, 3};
    tbl[11] = '{1'b0, 2'd3, 1'b0, 16'h0010, 32'h0,         32'h8001_BEEF, 1'b0, 2};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[12] = '{1'b1, 2'd2, 1'b0, 16'h0011, 32'hDEAD_BEEF, 32'h0, 1'b1, 1};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,         32'h8001_BEEF, 1'b0, 2};
`else
    tbl[12] = '{1'b1, 2'd2, 1'b0, 16'h0011, 32'hDEAD_BEEF, 32'h0, 1'b0, 2};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2};
`endif
    tbl[14] = '{1'b1, 2'd3, 1'b0, 16'h0020, 32'h1122_3344, 32'h0, 1'b0, 2};
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge clock);
    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    check("rst_mem_wen", {31'b0, bus.mem_wEn}, 32'd0);
    check("rst_mem_addr", {16'b0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 15; i++)
      txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd,
          tbl[i].rd, tbl[i].er, tbl[i].lat);
    check("vec_ram_0x20", ram[8], 32'h1122_3344);
    // Reset lands while the byte store sits in WRITE: the RMW must be dropped
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'd0;
    bus.req_addr = 16'h0021;
    bus.req_wdata = 32'h0000_0055;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("abort_access_wen", {31'b0, bus.mem_wEn}, 32'd0);
    @(negedge clock);
    check("abort_write_wen", {31'b0, bus.mem_wEn}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_wen_drop", {31'b0, bus.mem_wEn}, 32'd0);
    check("abort_ready", {31'b0, bus.req_ready}, 32'd1);
    check("abort_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("abort_mem_wdata", bus.mem_wdata, 32'd0);
    check("abort_mem_addr", {16'b0, bus.mem_addr}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    hits = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (bus.resp_valid || bus.mem_wEn) hits++;
    end
    check("abort_no_resp", 32'(hits), 32'd0);
    check("abort_ram", ram[8], 32'h1122_3344);
    check("abort_ready_after", {31'b0, bus.req_ready}, 32'd1);
    txn("abort_reload", 1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 32'h1122_3344, 1'b0, 2);
    // Request held and altered while the load is busy must not start a second access
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_size = 2'd2;
    bus.req_addr = 16'h0020;
    @(posedge clock);
    @(negedge clock);
    bus.req_we = 1'b1;
    bus.req_addr = 16'h0024;
    bus.req_wdata = 32'hFFFF_FFFF;
    hits = 0;
    check("hold_ready1", {31'b0, bus.req_ready}, 32'd0);
    if (bus.mem_wEn) hits++;
    @(negedge clock);
    check("hold_ready2", {31'b0, bus.req_ready}, 32'd0);
    check("hold_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
    check("hold_resp_rdata", bus.resp_rdata, 32'h1122_3344);
    if (bus.mem_wEn) hits++;
    @(negedge clock);
    bus.req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.mem_wEn || !bus.req_ready || bus.resp_valid) hits++;
      @(negedge clock);
    end
    check("hold_no_second", 32'(hits), 32'd0);
    check("hold_ram", ram[9], model[9]);
    for (int i = 0; i < 200; i++) begin
      logic we, uns, m;
      logic [1:0] sz;
      logic [15:0] a;
      logic [31:0] wd;
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = 16'($urandom_range(0, 63));
      wd = $urandom;
      m = mis(sz, a);
      txn($sformatf("rnd%0d", i), we, sz, uns, a, wd,
          (we || m) ? 32'h0 : model_load(sz, uns, a), m,
          m ? 1 : (we && sz < 2'd2) ? 3 : 2);
      if (we) check($sformatf("rnd%0d_ram", i), ram[a[7:2]], model[a[7:2]]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
